uart_ack_transmitter: RTL
=========================

Name: uart_ack_transmitter

Overview:
Parametrised successor to the single-byte external-communication transmitter. It serialises one DATA_WIDTH word as one or more UART frames and then waits for an acknowledgement byte on rx. If no valid ACK arrives, it retransmits up to RETRANSMIT_COUNT times before flagging failure. It sits between the master/slave bus side and the GPIO UART pins used for FPGA-to-FPGA communication.

Parameters:
DATA_WIDTH, 16, payload word width; any value ≥ 1
UART_WIDTH, 8, data bits per UART frame
CLK_FREQ, 50_000_000, clk frequency in Hz
BAUD_RATE, 230400, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, 217 at defaults)
RETRANSMIT_COUNT, 5, retries after the first attempt; total attempts = RETRANSMIT_COUNT+1
ACK_TIMEOUT_MS, 1, ACK wait window; TIMEOUT_CLKS = ACK_TIMEOUT_MS*CLK_FREQ/1000 (50000 at defaults)
ACK_BYTE, 8'b11001100, acknowledgement value; UART_WIDTH bits wide

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
data_in  input  DATA_WIDTH  word to send; sampled when start && ready
start  input  1  request; accepted only when ready=1
ready  output  1  high in IDLE only
tx  output  1  UART serial out; idles high
rx  input  1  UART serial in (ACK channel); asynchronous to clk
done  output  1  one-cycle pulse when a valid ACK is received
fail  output  1  one-cycle pulse when all attempts are exhausted
attempt  output  $clog2(RETRANSMIT_COUNT+2)  number of the attempt in progress (1-based); 0 in IDLE

Behaviour:
- Reset (async assert, sync deassert): tx=1, ready=1, done=0, fail=0, attempt=0, state=IDLE, all counters 0. An in-flight frame is abandoned immediately, with no stop bit emitted.
- NFRAMES = ceil(DATA_WIDTH/UART_WIDTH). The word is latched into a shadow register. Frames go out least-significant chunk first; the final chunk is zero-padded in its upper bits. Each frame is LSB-first.
- Frame format: 1 start bit (0), UART_WIDTH data bits, 1 stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles. Frames are sent back-to-back with no idle gap.
- State machine:
  - IDLE: on start && ready, latch data_in, set attempt=1, go to SEND. tx falls to 0 on the cycle after acceptance.
  - SEND: serialise NFRAMES frames. After the last stop bit completes, go to WAIT_ACK with the timeout counter cleared.
  - WAIT_ACK: the rx receiver is active and the timeout counter increments every cycle.
    - Byte received equal to ACK_BYTE: go to IDLE and pulse done in the same cycle.
    - Byte received not equal to ACK_BYTE, or timeout counter reaches TIMEOUT_CLKS-1: if attempt ≤ RETRANSMIT_COUNT, increment attempt and go to SEND, replaying the same latched word. Otherwise pulse fail and go to IDLE.
    - A byte that completes on the same cycle as the timeout is evaluated as a received byte; the byte takes priority.
- rx is passed through a 2-flop synchroniser before use.
- Start-bit detection: a falling edge, confirmed low at CLKS_PER_BIT/2. Each data bit is then sampled every CLKS_PER_BIT cycles.
- A stop bit sampled as 0 is a framing error, treated as a non-ACK byte.
- rx activity outside WAIT_ACK is ignored. A receive in progress is discarded when leaving WAIT_ACK.
- start asserted while ready=0 is ignored and not queued. data_in changes after acceptance have no effect.
- done and fail are never asserted in the same cycle. ready returns to 1 on the same cycle as the done or fail pulse.

Optional Feature:
UART_PARITY_EN
- Defined: an even-parity bit is inserted between the last data bit and the stop bit on tx, making frames UART_WIDTH+3 bits. The receiver expects the same format. A parity mismatch on a received byte is treated as a non-ACK, triggering retransmit or fail.
- Undefined: no parity bit on either direction; frames are UART_WIDTH+2 bits.

Test Plan:
- Defaults, data_in=16'hA53C, start -> tx carries frame 0x3C then frame 0xA5, totalling 20 bits × 217 = 4340 cycles. Bench then drives 8'b11001100 on rx -> single done pulse, attempt=1 before the pulse, ready=1 afterwards.
- No ACK driven -> a retransmit begins 50000 cycles after each last stop bit. After 6 identical transmissions, fail pulses once and done stays 0.
- ACK 8'hCD returned after attempt 1, then 8'hCC after attempt 2 -> immediate retransmit with no timeout wait, then done with attempt=2.
- rst asserted at mid-data-bit of frame 1 -> tx=1 and ready=1 asynchronously. A new start with 16'h0001 then produces frames 0x01, 0x00.
- DATA_WIDTH=12, data_in=12'hFED -> frames 0xED then 0x0F (padded). With UART_PARITY_EN defined, the parity bits are 0 and 0, and 11-bit frames are observed.
- start pulsed during WAIT_ACK with a different data_in -> ignored. The ACK path completes for the original word only.

Source files
------------

// File: rtl/uart_ack_transmitter.sv
// UART word transmitter with ACK wait, timeout and bounded retransmission.
// Define UART_PARITY_EN to add an even-parity bit to frames in both directions.
module uart_ack_transmitter #(
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned UART_WIDTH       = 8,
  parameter int unsigned CLK_FREQ         = 50_000_000,
  parameter int unsigned BAUD_RATE        = 230400,
  parameter int unsigned RETRANSMIT_COUNT = 5,
  parameter int unsigned ACK_TIMEOUT_MS   = 1,
  parameter logic [UART_WIDTH-1:0] ACK_BYTE = UART_WIDTH'(8'b11001100)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [DATA_WIDTH-1:0]                     data_in,
  input  logic                                      start,
  output logic                                      ready,
  output logic                                      tx,
  input  logic                                      rx,
  output logic                                      done,
  output logic                                      fail,
  output logic [$clog2(RETRANSMIT_COUNT+2)-1:0]     attempt
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam int unsigned TIMEOUT_CLKS =
      32'((longint'(ACK_TIMEOUT_MS) * longint'(CLK_FREQ)) / 1000);
  localparam int unsigned NFRAMES      = (DATA_WIDTH + UART_WIDTH - 1) / UART_WIDTH;
  localparam int unsigned PAD_W        = NFRAMES * UART_WIDTH;
`ifdef UART_PARITY_EN
  localparam int unsigned FRAME_BITS   = UART_WIDTH + 3;
`else
  localparam int unsigned FRAME_BITS   = UART_WIDTH + 2;
`endif
  localparam int unsigned ATT_W  = $clog2(RETRANSMIT_COUNT + 2);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BIT_W  = $clog2(FRAME_BITS + 1);
  localparam int unsigned FRM_W  = $clog2(NFRAMES + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {StIdle, StSend, StWaitAck} state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  // Frame bits in transmit order (bit 0 first): start, data LSB-first, [parity], stop.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [PAD_W-1:0] word,
                                                        input logic [FRM_W-1:0] idx);
    logic [UART_WIDTH-1:0] chunk;
    chunk = UART_WIDTH'(word >> (32'(idx) * UART_WIDTH));
`ifdef UART_PARITY_EN
    return {1'b1, ^chunk, chunk, 1'b0};
`else
    return {1'b1, chunk, 1'b0};
`endif
  endfunction

  state_e                 state_q, state_d;
  logic [PAD_W-1:0]       shadow_q, shadow_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [FRM_W-1:0]       frame_q, frame_d;
  logic [TO_W-1:0]        to_q, to_d;
  logic [ATT_W-1:0]       attempt_q, attempt_d;
  logic                   done_q, done_d, fail_q, fail_d;

  logic                   rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e              rx_state_q, rx_state_d;
  logic [BAUD_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
  logic [UART_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_par_ok_q, rx_par_ok_d;
  logic                   byte_done, byte_ack;

  // ACK receiver; held in RxIdle whenever the main FSM is not waiting for an ACK.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_data_d   = rx_data_q;
    rx_par_ok_d = rx_par_ok_q;
    byte_done   = 1'b0;
    byte_ack    = 1'b0;
    if (state_q != StWaitAck) begin
      rx_state_d = RxIdle;
    end else begin
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_d = RxStart;
            rx_cnt_d   = '0;
          end
        end
        RxStart: begin
          if (rx_cnt_q == BAUD_W'(HALF_BIT - 1)) begin
            rx_cnt_d    = '0;
            rx_bit_d    = '0;
            rx_par_ok_d = 1'b1;
            rx_state_d  = rx_sync_q ? RxIdle : RxData;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (rx_cnt_q == BAUD_W'(CLKS_PER_BIT - 1)) begin
            rx_cnt_d  = '0;
            rx_data_d = (rx_data_q >> 1) | (UART_WIDTH'(rx_sync_q) << (UART_WIDTH - 1));
            rx_bit_d  = rx_bit_q + 1'b1;
            if (rx_bit_q == BIT_W'(UART_WIDTH - 1)) begin
`ifdef UART_PARITY_EN
              rx_state_d = RxParity;
`else
              rx_state_d = RxStop;
`endif
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
        RxParity: begin
          if (rx_cnt_q == BAUD_W'(CLKS_PER_BIT - 1)) begin
            rx_cnt_d    = '0;
            rx_par_ok_d = ((^rx_data_q) == rx_sync_q);
            rx_state_d  = RxStop;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (rx_cnt_q == BAUD_W'(CLKS_PER_BIT - 1)) begin
            rx_state_d = RxIdle;
            byte_done  = 1'b1;
            // A low stop bit (framing error) or bad parity never counts as an ACK.
            byte_ack   = rx_sync_q && rx_par_ok_q && (rx_data_q == ACK_BYTE);
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_d = RxIdle;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    to_d      = to_q;
    attempt_d = attempt_q;
    done_d    = 1'b0;
    fail_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shadow_d  = PAD_W'(data_in);
          shift_d   = build_frame(PAD_W'(data_in), FRM_W'(0));
          tx_d      = 1'b0;
          baud_d    = '0;
          bit_d     = '0;
          frame_d   = '0;
          attempt_d = ATT_W'(1);
          state_d   = StSend;
        end
      end
      StSend: begin
        if (baud_q == BAUD_W'(CLKS_PER_BIT - 1)) begin
          baud_d = '0;
          if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            bit_d = '0;
            if (frame_q == FRM_W'(NFRAMES - 1)) begin
              tx_d    = 1'b1;
              to_d    = '0;
              state_d = StWaitAck;
            end else begin
              frame_d = frame_q + 1'b1;
              shift_d = build_frame(shadow_q, frame_q + 1'b1);
              tx_d    = 1'b0;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StWaitAck: begin
        to_d = to_q + 1'b1;
        if (byte_done && byte_ack) begin
          done_d    = 1'b1;
          attempt_d = '0;
          state_d   = StIdle;
        end else if (byte_done || (to_q == TO_W'(TIMEOUT_CLKS - 1))) begin
          if (attempt_q <= ATT_W'(RETRANSMIT_COUNT)) begin
            attempt_d = attempt_q + 1'b1;
            shift_d   = build_frame(shadow_q, FRM_W'(0));
            tx_d      = 1'b0;
            baud_d    = '0;
            bit_d     = '0;
            frame_d   = '0;
            state_d   = StSend;
          end else begin
            fail_d    = 1'b1;
            attempt_d = '0;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      shadow_q    <= '0;
      shift_q     <= '1;
      tx_q        <= 1'b1;
      baud_q      <= '0;
      bit_q       <= '0;
      frame_q     <= '0;
      to_q        <= '0;
      attempt_q   <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_data_q   <= '0;
      rx_par_ok_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      to_q        <= to_d;
      attempt_q   <= attempt_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_data_q   <= rx_data_d;
      rx_par_ok_q <= rx_par_ok_d;
    end
  end

  assign ready   = (state_q == StIdle);
  assign tx      = tx_q;
  assign done    = done_q;
  assign fail    = fail_q;
  assign attempt = attempt_q;

endmodule
